// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array edge logic: operand staggering modes
// and the per-lane delay rule used by the skew register and the array controller.
package systolic_pkg;

   typedef enum logic {
      MODE_SKEW   = 1'b0,
      MODE_DESKEW = 1'b1
   } mode_e;

   // Shift steps between a word entering lane `lane` and leaving it.
   function automatic int lane_delay(input int lane, input int lanes, input int skew,
                                     input mode_e mode);
      return (mode == MODE_DESKEW) ? 1 + (lanes - 1 - lane) * skew : 1 + lane * skew;
   endfunction

   function automatic int max_delay(input int lanes, input int skew);
      return 1 + (lanes - 1) * skew;
   endfunction

endpackage

// File: rtl/sft_reg_stage.sv
// One shift stage: WIDTH data bits plus a valid bit, with shift enable,
// synchronous clear and asynchronous active-low clear.
module sft_reg_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             clr,
   input  logic             sft,
   input  logic [WIDTH-1:0] d,
   input  logic             d_vld,
   output logic [WIDTH-1:0] q,
   output logic             q_vld
);

   // NOTE: sequential state uses non-blocking assignments so every stage samples its
   // neighbour's pre-edge value; blocking here would collapse the chain into one stage.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         q     <= '0;
         q_vld <= 1'b0;
      end else if (clr) begin
         q     <= '0;
         q_vld <= 1'b0;
      end else if (sft) begin
         q     <= d;
         q_vld <= d_vld;
      end
   end

endmodule

// File: rtl/systolic_skew_reg.sv
// Multi-lane skew/deskew shift register for the systolic array boundary: lane i is
// delayed by a lane-dependent number of shift steps selected by the registered mode.
module systolic_skew_reg
   import systolic_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LANES = 4,
   parameter int SKEW  = 1
) (
   input  logic                   clk,
   input  logic                   clr_n,
   input  logic                   clr,
   input  logic                   sft,
   input  logic                   mode,
   input  logic [LANES*WIDTH-1:0] d,
   input  logic [LANES-1:0]       d_vld,
   output logic [LANES*WIDTH-1:0] q,
   output logic [LANES-1:0]       q_vld,
   output logic                   busy,
   output logic                   mode_err
);

   localparam int MAXD = max_delay(LANES, SKEW);

   logic [WIDTH-1:0] stage_d [LANES][MAXD];
   logic [MAXD-1:0]  stage_v [LANES];
   mode_e            mode_q;

   // NOTE: every stage, not just the tapped ones, has a reset: busy looks at all valid
   // bits, so a stale valid left in an unreset stage would keep busy stuck high.
   for (genvar lane = 0; lane < LANES; lane++) begin : g_lane
      localparam int TAP_S = lane_delay(lane, LANES, SKEW, MODE_SKEW) - 1;
      localparam int TAP_D = lane_delay(lane, LANES, SKEW, MODE_DESKEW) - 1;

      for (genvar k = 0; k < MAXD; k++) begin : g_stage
         if (k == 0) begin : g_head
            // Invalid words enter as zero so downstream PEs accumulate nothing.
            sft_reg_stage #(.WIDTH(WIDTH)) u_stage (
               .clk   (clk),
               .clr_n (clr_n),
               .clr   (clr),
               .sft   (sft),
               .d     (d[lane*WIDTH +: WIDTH] & {WIDTH{d_vld[lane]}}),
               .d_vld (d_vld[lane]),
               .q     (stage_d[lane][k]),
               .q_vld (stage_v[lane][k])
            );
         end else begin : g_body
            sft_reg_stage #(.WIDTH(WIDTH)) u_stage (
               .clk   (clk),
               .clr_n (clr_n),
               .clr   (clr),
               .sft   (sft),
               .d     (stage_d[lane][k-1]),
               .d_vld (stage_v[lane][k-1]),
               .q     (stage_d[lane][k]),
               .q_vld (stage_v[lane][k])
            );
         end
      end

      assign q[lane*WIDTH +: WIDTH] = (mode_q == MODE_DESKEW) ? stage_d[lane][TAP_D]
                                                              : stage_d[lane][TAP_S];
      assign q_vld[lane]            = (mode_q == MODE_DESKEW) ? stage_v[lane][TAP_D]
                                                              : stage_v[lane][TAP_S];
   end

   // NOTE: busy is assigned a default before the loop so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      busy = 1'b0;
      for (int lane = 0; lane < LANES; lane++) begin
         busy = busy | (|stage_v[lane]);
      end
   end

   // Taps only move while the pipeline is empty, so no word is dropped or duplicated.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         mode_q   <= MODE_SKEW;
         mode_err <= 1'b0;
      end else begin
         mode_err <= 1'b0;
         if (!busy || clr) begin
            mode_q <= mode_e'(mode);
         end else if (mode_e'(mode) != mode_q) begin
            mode_err <= 1'b1;
         end
      end
   end

endmodule
